// File: rtl/sdram_slot_arbiter_if.sv
// Signal bundle between the CPU/video requesters, the slot arbiter and the SDRAM controller request port.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface sdram_slot_arbiter_if;
    logic        clkref;

    logic [24:0] cpu_addr;
    logic [15:0] cpu_din;
    logic        cpu_uds;
    logic        cpu_lds;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_dout;
    logic        cpu_ack;

    logic [24:0] vid_addr;
    logic        vid_req;
    logic [15:0] vid_dout;
    logic        vid_ack;

    logic [24:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_uds;
    logic        ram_lds;
    logic        ram_oe;
    logic        ram_we;
    logic [15:0] ram_dout;

    modport master (
        output clkref, cpu_addr, cpu_din, cpu_uds, cpu_lds, cpu_rd, cpu_wr,
               vid_addr, vid_req, ram_dout,
        input  cpu_dout, cpu_ack, vid_dout, vid_ack,
               ram_addr, ram_din, ram_uds, ram_lds, ram_oe, ram_we
    );

    modport slave (
        input  clkref, cpu_addr, cpu_din, cpu_uds, cpu_lds, cpu_rd, cpu_wr,
               vid_addr, vid_req, ram_dout,
        output cpu_dout, cpu_ack, vid_dout, vid_ack,
               ram_addr, ram_din, ram_uds, ram_lds, ram_oe, ram_we
    );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter: hands each clkref-long SDRAM slot to video, CPU or nobody (refresh).
// Define SDRAM_ARB_REFRESH_EN to force an idle slot after REFRESH_SLOTS consecutive granted slots.
module sdram_slot_arbiter #(
    parameter int REFRESH_SLOTS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    sdram_slot_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_VID,
        OWN_CPU_RD,
        OWN_CPU_WR
    } owner_t;

    owner_t      r_owner;
    owner_t      w_ownerNext;
    logic [2:0]  r_ph;
    logic [2:0]  w_phNext;
    logic        w_boundary;
    logic        w_forceIdle;
    logic [24:0] r_ramAddr;
    logic [15:0] r_ramDin;
    logic        r_ramUds;
    logic        r_ramLds;
    logic        r_ramOe;
    logic        r_ramWe;
    logic [15:0] r_cpuDout;
    logic [15:0] r_vidDout;
    logic        r_cpuAck;
    logic        r_vidAck;

    // Phase parks at 7 while clkref is high and at 0 while it is low, tracking the controller's counter.
    always_comb begin
        w_phNext = r_ph + 3'd1;
        if ((bus.clkref && r_ph == 3'd7) || (!bus.clkref && r_ph == 3'd0))
            w_phNext = r_ph;
    end

    assign w_boundary = (r_ph == 3'd7) && !bus.clkref;

`ifdef SDRAM_ARB_REFRESH_EN
    localparam logic [7:0] LP_LIMIT = 8'(REFRESH_SLOTS);

    logic [7:0] r_busyCnt;

    assign w_forceIdle = (r_busyCnt == LP_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busyCnt <= '0;
        end else if (w_boundary) begin
            if (w_ownerNext == OWN_IDLE)
                r_busyCnt <= '0;
            else if (r_busyCnt != LP_LIMIT)
                r_busyCnt <= r_busyCnt + 8'd1;
        end
    end
`else
    assign w_forceIdle = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_owner <= OWN_IDLE;
        else if (w_boundary)
            r_owner <= w_ownerNext;
    end

    // The port finishing at this boundary sits out this grant so its stale request is not served twice.
    always_comb begin
        w_ownerNext = OWN_IDLE;
        if (!w_forceIdle) begin
            if (bus.vid_req && r_owner != OWN_VID)
                w_ownerNext = OWN_VID;
            else if ((bus.cpu_rd || bus.cpu_wr) && r_owner != OWN_CPU_RD && r_owner != OWN_CPU_WR)
                w_ownerNext = bus.cpu_wr ? OWN_CPU_WR : OWN_CPU_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ph      <= 3'd7;
            r_ramAddr <= '0;
            r_ramDin  <= '0;
            r_ramUds  <= 1'b0;
            r_ramLds  <= 1'b0;
            r_ramOe   <= 1'b0;
            r_ramWe   <= 1'b0;
            r_cpuDout <= '0;
            r_vidDout <= '0;
            r_cpuAck  <= 1'b0;
            r_vidAck  <= 1'b0;
        end else begin
            r_ph     <= w_phNext;
            r_cpuAck <= 1'b0;
            r_vidAck <= 1'b0;
            if (w_boundary) begin
                case (r_owner)
                    OWN_VID: begin
                        r_vidDout <= bus.ram_dout;
                        r_vidAck  <= 1'b1;
                    end
                    OWN_CPU_RD: begin
                        r_cpuDout <= bus.ram_dout;
                        r_cpuAck  <= 1'b1;
                    end
                    OWN_CPU_WR: r_cpuAck <= 1'b1;
                    default: ;
                endcase
                case (w_ownerNext)
                    OWN_VID: begin
                        r_ramAddr <= bus.vid_addr;
                        r_ramUds  <= 1'b1;
                        r_ramLds  <= 1'b1;
                        r_ramOe   <= 1'b1;
                        r_ramWe   <= 1'b0;
                    end
                    OWN_CPU_RD, OWN_CPU_WR: begin
                        r_ramAddr <= bus.cpu_addr;
                        r_ramDin  <= bus.cpu_din;
                        r_ramUds  <= bus.cpu_uds;
                        r_ramLds  <= bus.cpu_lds;
                        r_ramOe   <= bus.cpu_rd & ~bus.cpu_wr;
                        r_ramWe   <= bus.cpu_wr;
                    end
                    default: begin
                        r_ramUds <= 1'b0;
                        r_ramLds <= 1'b0;
                        r_ramOe  <= 1'b0;
                        r_ramWe  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ram_addr = r_ramAddr;
    assign bus.ram_din  = r_ramDin;
    assign bus.ram_uds  = r_ramUds;
    assign bus.ram_lds  = r_ramLds;
    assign bus.ram_oe   = r_ramOe;
    assign bus.ram_we   = r_ramWe;
    assign bus.cpu_dout = r_cpuDout;
    assign bus.cpu_ack  = r_cpuAck;
    assign bus.vid_dout = r_vidDout;
    assign bus.vid_ack  = r_vidAck;
endmodule
